// File: rtl/fma_writeback.sv
// fma_writeback: result-side companion of the shader-core FMA unit.
// Tracks ops issued into the fixed-latency FMA pipeline, captures each 18-bit
// result with its destination tag, and buffers it in a show-ahead FIFO for the
// register-file write port. Issue is credit-gated so every result has a slot.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   issue_valid/issue_tag    op presented to the FMA unit and its destination tag
//   issue_ready              credit available (accept = issue_valid & issue_ready)
//   q                        FMA pipeline result, valid LATENCY cycles after accept
//   wb_valid/wb_ready        head-of-FIFO handshake towards the register file
//   wb_tag/wb_data           head result tag and value
//   wb_flags                 {nan_inf, neg, zero} of head result (FMA_WB_FLAGS_EN only)
//   in_flight                credits in use (pipeline + FIFO)
//
// Build option: define FMA_WB_FLAGS_EN to add the wb_flags classification output.
module fma_writeback #(
  parameter int unsigned LATENCY    = 5,
  parameter int unsigned TAG_W      = 4,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               issue_valid,
  input  logic [TAG_W-1:0]                   issue_tag,
  output logic                               issue_ready,
  input  logic [17:0]                        q,
  output logic                               wb_valid,
  input  logic                               wb_ready,
  output logic [TAG_W-1:0]                   wb_tag,
  output logic [17:0]                        wb_data,
`ifdef FMA_WB_FLAGS_EN
  output logic [2:0]                         wb_flags,
`endif
  output logic [$clog2(FIFO_DEPTH):0]        in_flight
);

  localparam int unsigned DATA_W = 18;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
`ifdef FMA_WB_FLAGS_EN
  localparam int unsigned FLAG_W  = 3;
  localparam int unsigned ENTRY_W = FLAG_W + TAG_W + DATA_W;
`else
  localparam int unsigned ENTRY_W = TAG_W + DATA_W;
`endif

  logic               accept;
  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic [ENTRY_W-1:0] push_entry;
  logic [ENTRY_W-1:0] head;

  logic [LATENCY-1:0] dl_vld;
  logic [TAG_W-1:0]   dl_tag [LATENCY];

  logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
  logic [CNT_W-1:0]   wr_ptr;
  logic [CNT_W-1:0]   rd_ptr;

  // Credit gate: in_flight never exceeds FIFO_DEPTH, so a push always finds room.
  assign issue_ready = !rst && (in_flight < CNT_W'(FIFO_DEPTH));
  assign accept      = issue_valid && issue_ready;

  // Delay line mirrors the FMA pipeline so the tag meets its result.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_vld <= '0;
      for (int i = 0; i < int'(LATENCY); i++) dl_tag[i] <= '0;
    end else begin
      dl_vld[0] <= accept;
      dl_tag[0] <= issue_tag;
      for (int i = 1; i < int'(LATENCY); i++) begin
        dl_vld[i] <= dl_vld[i-1];
        dl_tag[i] <= dl_tag[i-1];
      end
    end
  end

  assign push = dl_vld[LATENCY-1];

`ifdef FMA_WB_FLAGS_EN
  logic [FLAG_W-1:0] push_flags;
  assign push_flags = {q[16:11] == 6'h3F, q[17], q[16:0] == 17'd0};
  assign push_entry = {push_flags, dl_tag[LATENCY-1], q};
`else
  assign push_entry = {dl_tag[LATENCY-1], q};
`endif

  // Pointers carry one extra wrap bit to tell full from empty.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                 (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop   = wb_valid && wb_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr[PTR_W-1:0]] <= push_entry;
        wr_ptr                 <= wr_ptr + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + CNT_W'(1);
    end
  end

  // Overflow cannot happen while the credit gate holds.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && full)) else $error("fma_writeback: push into full FIFO");
    end
  end

  // Credit counter: +1 on accept, -1 on pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   in_flight <= in_flight + CNT_W'(1);
        2'b01:   in_flight <= in_flight - CNT_W'(1);
        default: in_flight <= in_flight;
      endcase
    end
  end

  // Show-ahead head: outputs come straight from the storage registers.
  assign head     = mem[rd_ptr[PTR_W-1:0]];
  assign wb_valid = !empty;
  assign wb_data  = head[DATA_W-1:0];
  assign wb_tag   = head[DATA_W +: TAG_W];
`ifdef FMA_WB_FLAGS_EN
  assign wb_flags = head[DATA_W+TAG_W +: FLAG_W];
`endif

endmodule

// File: tb/tb_fma_writeback.sv
// Directed bench for fma_writeback. A small FMA pipeline model returns the
// operand presented at issue as q LATENCY cycles later; a scoreboard queue
// tracks accepted ops and checks every popped result in order.
module tb_fma_writeback;

  localparam int unsigned TAG_W = 4;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic [3:0]  issue_tag;
  logic        issue_ready;
  logic [17:0] issue_data;
  logic [17:0] q;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  wb_tag;
  logic [17:0] wb_data;
  logic [3:0]  in_flight;
`ifdef FMA_WB_FLAGS_EN
  logic [2:0]  wb_flags;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [3:0]  tag;
    logic [17:0] data;
  } exp_t;

  exp_t exp_q[$];

  fma_writeback #(.LATENCY(5), .TAG_W(TAG_W), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_tag   (issue_tag),
    .issue_ready (issue_ready),
    .q           (q),
    .wb_valid    (wb_valid),
    .wb_ready    (wb_ready),
    .wb_tag      (wb_tag),
    .wb_data     (wb_data),
`ifdef FMA_WB_FLAGS_EN
    .wb_flags    (wb_flags),
`endif
    .in_flight   (in_flight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // FMA pipeline model: operands in cycle N appear as q in cycle N+5.
  bit [17:0] pipe [5];
  always @(posedge clk) begin
    pipe[0] <= issue_data;
    for (int i = 1; i < 5; i++) pipe[i] <= pipe[i-1];
  end
  assign q = pipe[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: record accepts, check pops in order; reset discards everything.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (wb_valid && wb_ready) begin
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("sb_tag", 32'(wb_tag), 32'(e.tag));
          check("sb_data", 32'(wb_data), 32'(e.data));
        end
      end
      if (issue_valid && issue_ready) exp_q.push_back('{tag: issue_tag, data: issue_data});
    end
  end

  // Pop until all credits return, then confirm the block is idle.
  task automatic drain(input string name);
    issue_valid = 1'b0;
    wb_ready    = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (in_flight == 4'd0) break;
      next_cycle();
    end
    check({name, "_in_flight"}, 32'(in_flight), 32'd0);
    check({name, "_wb_valid"}, 32'(wb_valid), 32'd0);
    check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
    next_cycle();
    wb_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    rst         = 1'b1;
    issue_valid = 1'b0;
    issue_tag   = '0;
    issue_data  = '0;
    wb_ready    = 1'b0;

    // Reset state
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_issue_ready", 32'(issue_ready), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_wb_tag", 32'(wb_tag), 32'd0);
    check("rst_wb_data", 32'(wb_data), 32'd0);
    check("rst_in_flight", 32'(in_flight), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_issue_ready", 32'(issue_ready), 32'd1);
    next_cycle();

    // 1: single op, exact latency
    issue_valid = 1'b1;
    issue_tag   = 4'd3;
    issue_data  = 18'h0F800;
    next_cycle();
    issue_valid = 1'b0;
    issue_data  = 18'h3FFFF;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      check("t1_not_yet_valid", 32'(wb_valid), 32'd0);
      next_cycle();
    end
    @(negedge clk);
    check("t1_wb_valid", 32'(wb_valid), 32'd1);
    check("t1_wb_tag", 32'(wb_tag), 32'd3);
    check("t1_wb_data", 32'(wb_data), 32'h0F800);
    check("t1_in_flight_1", 32'(in_flight), 32'd1);
    next_cycle();
    wb_ready = 1'b1;
    next_cycle();
    wb_ready = 1'b0;
    @(negedge clk);
    check("t1_in_flight_0", 32'(in_flight), 32'd0);
    check("t1_wb_valid_0", 32'(wb_valid), 32'd0);
    next_cycle();

    // 2: credit stall with continuous issue
    k = 0;
    issue_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      issue_tag  = 4'(k);
      issue_data = 18'(18'h100 + k);
      @(negedge clk);
      if (issue_ready) k++;
      next_cycle();
    end
    @(negedge clk);
    check("t2_accepts", 32'(k), 32'd8);
    check("t2_issue_ready", 32'(issue_ready), 32'd0);
    check("t2_in_flight", 32'(in_flight), 32'd8);
    check("t2_head_tag", 32'(wb_tag), 32'd0);
    check("t2_head_data", 32'(wb_data), 32'h100);
    next_cycle();

    // 3: full FIFO, pop while issue is held, then pop + accept together
    issue_tag  = 4'd8;
    issue_data = 18'h108;
    wb_ready   = 1'b1;
    @(negedge clk);
    check("t3_full_no_credit", 32'(issue_ready), 32'd0);
    next_cycle();
    @(negedge clk);
    check("t3_after_pop_in_flight", 32'(in_flight), 32'd7);
    check("t3_after_pop_ready", 32'(issue_ready), 32'd1);
    check("t3_after_pop_head", 32'(wb_tag), 32'd1);
    next_cycle();
    wb_ready   = 1'b0;
    issue_tag  = 4'd9;
    issue_data = 18'h109;
    @(negedge clk);
    check("t3_pop_accept_in_flight", 32'(in_flight), 32'd7);
    next_cycle();
    issue_valid = 1'b0;
    @(negedge clk);
    check("t3_refill_in_flight", 32'(in_flight), 32'd8);
    check("t3_refill_ready", 32'(issue_ready), 32'd0);
    repeat (7) next_cycle();
    @(negedge clk);
    check("t3_fifo_full_head", 32'(wb_tag), 32'd2);
    next_cycle();
    drain("t3_drain");

    // 4: 20 ops, random backpressure, order and pointer wrap
    k = 0;
    for (int c = 0; c < 400 && k < 20; c++) begin
      issue_valid = 1'b1;
      issue_tag   = 4'(k);
      issue_data  = 18'(18'h2000 + k * 37);
      wb_ready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (issue_ready) k++;
      next_cycle();
    end
    issue_valid = 1'b0;
    check("t4_issued", 32'(k), 32'd20);
    drain("t4_drain");

    // 5: reset with results both in pipeline and in FIFO
    wb_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      issue_valid = 1'b1;
      issue_tag   = 4'(10 + i);
      issue_data  = 18'(18'h3000 + i);
      next_cycle();
    end
    issue_valid = 1'b0;
    repeat (6) next_cycle();
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1;
      issue_tag   = 4'(12 + i);
      issue_data  = 18'(18'h3100 + i);
      next_cycle();
    end
    issue_valid = 1'b0;
    @(negedge clk);
    check("t5_pre_in_flight", 32'(in_flight), 32'd5);
    check("t5_pre_wb_valid", 32'(wb_valid), 32'd1);
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_issue_ready", 32'(issue_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    check("t5_wb_valid", 32'(wb_valid), 32'd0);
    check("t5_in_flight", 32'(in_flight), 32'd0);
    check("t5_issue_ready", 32'(issue_ready), 32'd1);
    next_cycle();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("t5_no_ghost", 32'(wb_valid), 32'd0);
      next_cycle();
    end

`ifdef FMA_WB_FLAGS_EN
    // 6: result classification flags
    begin
      logic [17:0] t6_q [3];
      logic [2:0]  t6_f [3];
      int          j;
      t6_q[0] = 18'h20000; t6_f[0] = 3'b011;
      t6_q[1] = 18'h1F800; t6_f[1] = 3'b100;
      t6_q[2] = 18'h0F800; t6_f[2] = 3'b000;
      wb_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
        issue_valid = 1'b1;
        issue_tag   = 4'(i);
        issue_data  = t6_q[i];
        next_cycle();
      end
      issue_valid = 1'b0;
      j = 0;
      for (int c = 0; c < 20 && j < 3; c++) begin
        @(negedge clk);
        if (wb_valid) begin
          check("t6_flags", 32'(wb_flags), 32'(t6_f[j]));
          j++;
        end
        next_cycle();
      end
      check("t6_results_seen", 32'(j), 32'd3);
      drain("t6_drain");
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
